// File: rtl/mips_io_controller_if.sv
// rtl/mips_io_controller_if.sv - data-memory bus between the core and the I/O controller
interface mips_io_controller_if #(
  parameter int DATA_WIDTH = 32
);
  logic [31:0]           Address;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  MemWrite;
  logic                  MemRead;
  logic                  Hit;
  logic [DATA_WIDTH-1:0] ReadData;

  modport master (
    output Address, WriteData, MemWrite, MemRead,
    input  Hit, ReadData
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead,
    output Hit, ReadData
  );
endinterface

// File: rtl/mips_io_controller.sv
// rtl/mips_io_controller.sv - memory-mapped port, edge capture, timer and interrupt block
module mips_io_controller #(
  parameter logic [31:0] BASE_ADDR     = 32'h1001_0040,
  parameter int          DATA_WIDTH    = 32,
  parameter int          PORT_IN_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  mips_io_controller_if.slave      bus,
  input  logic [PORT_IN_WIDTH-1:0] PortIn,
  output logic [DATA_WIDTH-1:0]    PortOut,
  output logic                     Irq
);

  localparam logic [2:0] OFF_PORT_OUT    = 3'd0;
  localparam logic [2:0] OFF_PORT_IN     = 3'd1;
  localparam logic [2:0] OFF_EDGE_STAT   = 3'd2;
  localparam logic [2:0] OFF_TIMER_LOAD  = 3'd3;
  localparam logic [2:0] OFF_TIMER_CTRL  = 3'd4;
  localparam logic [2:0] OFF_IRQ_EN      = 3'd5;
  localparam logic [2:0] OFF_TIMER_COUNT = 3'd6;

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  // window decode: the upper 27 address bits select the 32-byte block
  logic       hit;
  logic       aligned;
  logic [2:0] offset;
  logic       wr_en;

  assign hit     = (bus.Address[31:5] == BASE_ADDR[31:5]);
  assign aligned = (bus.Address[1:0] == 2'b00);
  assign offset  = bus.Address[4:2];
  assign wr_en   = bus.MemWrite & hit & aligned;
  assign bus.Hit = hit;

  logic wr_port_out, wr_edge_stat, wr_load, wr_ctrl, wr_irq_en;

  assign wr_port_out  = wr_en & (offset == OFF_PORT_OUT);
  assign wr_edge_stat = wr_en & (offset == OFF_EDGE_STAT);
  assign wr_load      = wr_en & (offset == OFF_TIMER_LOAD);
  assign wr_ctrl      = wr_en & (offset == OFF_TIMER_CTRL);
  assign wr_irq_en    = wr_en & (offset == OFF_IRQ_EN);

  // registered state
  logic [DATA_WIDTH-1:0]    port_out;
  logic [PORT_IN_WIDTH-1:0] s1, s2, prev;
  logic [1:0]               warm;
  logic [PORT_IN_WIDTH-1:0] edge_stat;
  logic [DATA_WIDTH-1:0]    load;
  logic [DATA_WIDTH-1:0]    count;
  logic                     en, auto_rl, expd;
  logic [PORT_IN_WIDTH-1:0] edge_mask;
  logic                     timer_ie;

  logic [PORT_IN_WIDTH-1:0] rise;
  logic                     expire;

  // prev tracks s1 until the pipe holds post-reset samples, so a level already high
  // at reset release is taken as the baseline instead of a rising edge
  assign rise   = s2 & ~prev;
  assign expire = en & (count == ONE) & ~wr_load;

  // output port register
  always_ff @(posedge clk) begin
    if (!reset) begin
      port_out <= '0;
    end else if (wr_port_out) begin
      port_out <= bus.WriteData;
    end
  end

  // two-flop synchronizer plus the previous synchronized sample for edge detection
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
      warm <= 2'd0;
    end else begin
      s1   <= PortIn;
      s2   <= s1;
      prev <= (warm == 2'd2) ? s2 : s1;
      if (warm != 2'd2) begin
        warm <= warm + 2'd1;
      end
    end
  end

  // sticky rising-edge flags; a new rise beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      edge_stat <= '0;
    end else begin
      edge_stat <= (edge_stat & ~(wr_edge_stat ? bus.WriteData[PORT_IN_WIDTH-1:0] : '0)) | rise;
    end
  end

  // countdown timer: a load write beats counting; expiry reloads or stops the timer
  always_ff @(posedge clk) begin
    if (!reset) begin
      load    <= '0;
      count   <= '0;
      en      <= 1'b0;
      auto_rl <= 1'b0;
      expd    <= 1'b0;
    end else begin
      if (wr_load) begin
        load  <= bus.WriteData;
        count <= bus.WriteData;
      end else if (expire) begin
        count <= auto_rl ? load : '0;
      end else if (en && count > ONE) begin
        count <= count - ONE;
      end

      if (wr_ctrl) begin
        en      <= bus.WriteData[0];
        auto_rl <= bus.WriteData[1];
      end else if (expire && !auto_rl) begin
        en <= 1'b0;
      end

      expd <= (expd & ~(wr_ctrl & bus.WriteData[2])) | expire;
    end
  end

  // interrupt enables: edge mask and timer enable
  always_ff @(posedge clk) begin
    if (!reset) begin
      edge_mask <= '0;
      timer_ie  <= 1'b0;
    end else if (wr_irq_en) begin
      edge_mask <= bus.WriteData[PORT_IN_WIDTH-1:0];
      timer_ie  <= bus.WriteData[8];
    end
  end

  assign PortOut = port_out;
  assign Irq     = (|(edge_stat & edge_mask)) | (expd & timer_ie);

  // read mux: zero unless an aligned load hits the window
  always_comb begin
    logic [DATA_WIDTH-1:0] irq_en_word;
    irq_en_word                    = '0;
    irq_en_word[PORT_IN_WIDTH-1:0] = edge_mask;
    irq_en_word[8]                 = timer_ie;
    bus.ReadData = '0;
    if (bus.MemRead && hit && aligned) begin
      case (offset)
        OFF_PORT_OUT:    bus.ReadData = port_out;
        OFF_PORT_IN:     bus.ReadData = DATA_WIDTH'(s2);
        OFF_EDGE_STAT:   bus.ReadData = DATA_WIDTH'(edge_stat);
        OFF_TIMER_LOAD:  bus.ReadData = load;
        OFF_TIMER_CTRL:  bus.ReadData = DATA_WIDTH'({expd, auto_rl, en});
        OFF_IRQ_EN:      bus.ReadData = irq_en_word;
        OFF_TIMER_COUNT: bus.ReadData = count;
        default:         bus.ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_io_controller.sv
// tb/tb_mips_io_controller.sv - self-checking bench for mips_io_controller
module tb_mips_io_controller;
  localparam logic [31:0] BASE = 32'h1001_0040;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pin;
  logic [31:0] port_out;
  logic        irq;

  always #5 clk = ~clk;

  mips_io_controller_if #(.DATA_WIDTH(32)) bus ();

  mips_io_controller #(.BASE_ADDR(BASE), .DATA_WIDTH(32), .PORT_IN_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .PortIn(pin), .PortOut(port_out), .Irq(irq)
  );

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] m_port_out = 0, m_load = 0, m_count = 0;
  logic [7:0]  m_stat = 0, m_mask = 0;
  logic        m_en = 0, m_auto = 0, m_exp = 0, m_tie = 0;
  logic [7:0]  samp[$];
  int          k = 0;
  logic [7:0]  cur_pin = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'd31);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic re);
    if (!(re && in_window(a) && a[1:0] == 2'b00)) return 32'h0;
    case ((a - BASE) / 4)
      0: return m_port_out;
      1: return (k >= 2) ? {24'h0, samp[samp.size()-2]} : 32'h0;
      2: return {24'h0, m_stat};
      3: return m_load;
      4: return {29'h0, m_exp, m_auto, m_en};
      5: return {23'h0, m_tie, m_mask};
      6: return m_count;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_irq();
    return (|(m_stat & m_mask)) | (m_exp & m_tie);
  endfunction

  task automatic m_edge(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                        input logic we, input logic [7:0] p);
    int off;
    logic [7:0] rise;
    bit expire;
    if (!rst) begin
      m_port_out = 0; m_load = 0; m_count = 0; m_stat = 0; m_mask = 0;
      m_en = 0; m_auto = 0; m_exp = 0; m_tie = 0;
      samp.delete(); k = 0;
      return;
    end
    off = (we && in_window(a) && a[1:0] == 2'b00) ? int'((a - BASE) / 4) : -1;
    samp.push_back(p);
    if (samp.size() > 4) void'(samp.pop_front());
    if (k < 4) k++;
    rise = (k >= 4) ? (samp[1] & ~samp[0]) : 8'h00;
    m_stat = (m_stat & ~((off == 2) ? wd[7:0] : 8'h00)) | rise;
    if (off == 0) m_port_out = wd;
    if (off == 5) begin m_mask = wd[7:0]; m_tie = wd[8]; end
    expire = 0;
    if (off == 3) begin
      m_load = wd; m_count = wd;
    end else if (m_en && m_count != 0) begin
      if (m_count == 1) begin
        expire = 1;
        m_count = m_auto ? m_load : 32'h0;
      end else begin
        m_count = m_count - 1;
      end
    end
    if (off == 4) begin
      m_en = wd[0]; m_auto = wd[1];
      if (wd[2]) m_exp = 0;
    end else if (expire && !m_auto) begin
      m_en = 0;
    end
    if (expire) m_exp = 1;
  endtask

  // one bus cycle: drive at negedge, check combinational outputs, step model at posedge
  task automatic cyc(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                     input logic we, input logic re, input logic [7:0] p,
                     output logic [31:0] rd, output logic hit);
    @(negedge clk);
    reset = rst; bus.Address = a; bus.WriteData = wd;
    bus.MemWrite = we; bus.MemRead = re; pin = p;
    #1;
    rd = bus.ReadData;
    hit = bus.Hit;
    check("hit", {31'h0, bus.Hit}, {31'h0, in_window(a)});
    check("read_data", bus.ReadData, m_read(a, re));
    @(posedge clk);
    m_edge(rst, a, wd, we, p);
    #1;
    check("port_out", port_out, m_port_out);
    check("irq", {31'h0, irq}, {31'h0, m_irq()});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd; logic h;
    cyc(1'b1, a, d, 1'b1, 1'b0, cur_pin, rd, h);
  endtask

  task automatic rdchk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic h;
    cyc(1'b1, a, 32'h0, 1'b0, 1'b1, cur_pin, rd, h);
    check(name, rd, exp);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
    logic        exp_hit;
    logic [31:0] exp_out;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [31:0] rd;
    logic        h;

    tbl[0] = '{BASE + 32'h00, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'hDEAD_BEEF};
    tbl[1] = '{BASE + 32'h20, 32'h1234_5678, 1'b1, 1'b0, 32'hDEAD_BEEF};
    tbl[2] = '{BASE - 32'h04, 32'h1111_1111, 1'b1, 1'b0, 32'hDEAD_BEEF};
    tbl[3] = '{BASE + 32'h01, 32'h2222_2222, 1'b1, 1'b1, 32'hDEAD_BEEF};
    tbl[4] = '{BASE + 32'h1C, 32'h3333_3333, 1'b1, 1'b1, 32'hDEAD_BEEF};
    tbl[5] = '{BASE + 32'h04, 32'h4444_4444, 1'b1, 1'b1, 32'hDEAD_BEEF};
    tbl[6] = '{BASE + 32'h18, 32'h5555_5555, 1'b1, 1'b1, 32'hDEAD_BEEF};
    tbl[7] = '{BASE + 32'h1F, 32'h6666_6666, 1'b0, 1'b1, 32'hDEAD_BEEF};
    tbl[8] = '{BASE + 32'h00, 32'h0000_00A5, 1'b1, 1'b1, 32'h0000_00A5};
    tbl[9] = '{BASE + 32'h00, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_00A5};

    reset = 1'b0; bus.Address = 0; bus.WriteData = 0;
    bus.MemWrite = 0; bus.MemRead = 0; pin = 0;
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h00, rd, h);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h00, rd, h);
    check("reset_port_out", port_out, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);

    // decode and write qualification
    foreach (tbl[i]) begin
      cyc(1'b1, tbl[i].addr, tbl[i].wd, tbl[i].we, 1'b0, cur_pin, rd, h);
      check($sformatf("tbl%0d_hit", i), {31'h0, h}, {31'h0, tbl[i].exp_hit});
      check($sformatf("tbl%0d_port_out", i), port_out, tbl[i].exp_out);
      rdchk($sformatf("tbl%0d_readback", i), BASE, tbl[i].exp_out);
    end
    rdchk("count_ro", BASE + 32'h18, 32'h0);
    rdchk("misaligned_read", BASE + 32'h01, 32'h0);

    // synchronizer latency, edge capture, masked interrupt, W1C
    wr(BASE + 32'h14, 32'h04);
    cur_pin = 8'h05;
    rdchk("port_in_edge_n", BASE + 32'h04, 32'h0);
    rdchk("port_in_edge_n1", BASE + 32'h04, 32'h0);
    rdchk("port_in_after_n1", BASE + 32'h04, 32'h05);
    check("irq_edge", {31'h0, irq}, 32'h1);
    rdchk("edge_stat", BASE + 32'h08, 32'h05);
    wr(BASE + 32'h08, 32'h04);
    check("irq_cleared", {31'h0, irq}, 32'h0);
    rdchk("edge_stat_w1c", BASE + 32'h08, 32'h01);

    // W1C coincident with a new rise: set wins; bit0 clears
    cur_pin = 8'h07;
    rdchk("stat_hold_a", BASE + 32'h08, 32'h01);
    rdchk("stat_hold_b", BASE + 32'h08, 32'h01);
    wr(BASE + 32'h08, 32'h03);
    rdchk("stat_set_wins", BASE + 32'h08, 32'h02);
    wr(BASE + 32'h09, 32'hFF);
    rdchk("stat_misaligned", BASE + 32'h08, 32'h02);

    // one-shot timer
    wr(BASE + 32'h0C, 32'd3);
    wr(BASE + 32'h10, 32'h1);
    rdchk("count3", BASE + 32'h18, 32'd3);
    rdchk("count2", BASE + 32'h18, 32'd2);
    rdchk("count1", BASE + 32'h18, 32'd1);
    rdchk("count0", BASE + 32'h18, 32'd0);
    rdchk("ctrl_oneshot", BASE + 32'h10, 32'h4);
    rdchk("count_stays0", BASE + 32'h18, 32'd0);
    check("irq_no_tie", {31'h0, irq}, 32'h0);

    // auto-reload timer with interrupt
    wr(BASE + 32'h10, 32'h4);
    wr(BASE + 32'h14, 32'h104);
    wr(BASE + 32'h0C, 32'd2);
    wr(BASE + 32'h10, 32'h3);
    rdchk("auto_c2", BASE + 32'h18, 32'd2);
    rdchk("auto_c1", BASE + 32'h18, 32'd1);
    check("irq_timer", {31'h0, irq}, 32'h1);
    wr(BASE + 32'h10, 32'h7);
    check("exp_w1c", {31'h0, irq}, 32'h0);
    wr(BASE + 32'h10, 32'h7);
    check("exp_expiry_wins", {31'h0, irq}, 32'h1);
    rdchk("ctrl_auto", BASE + 32'h10, 32'h7);
    rdchk("auto_c1b", BASE + 32'h18, 32'd1);

    // reset mid-count with a concurrent store
    wr(BASE + 32'h10, 32'h0);
    wr(BASE + 32'h00, 32'h5);
    wr(BASE + 32'h0C, 32'd10);
    wr(BASE + 32'h10, 32'h1);
    rdchk("count10", BASE + 32'h18, 32'd10);
    check("port_out5", port_out, 32'h5);
    cyc(1'b0, BASE, 32'h99, 1'b1, 1'b0, cur_pin, rd, h);
    check("rst_port_out", port_out, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rdchk("rst_count", BASE + 32'h18, 32'h0);
    rdchk("rst_ctrl", BASE + 32'h10, 32'h0);
    rdchk("rst_load", BASE + 32'h0C, 32'h0);
    rdchk("rst_irq_en", BASE + 32'h14, 32'h0);
    rdchk("rst_stat", BASE + 32'h08, 32'h0);
    rdchk("rst_count_stopped", BASE + 32'h18, 32'h0);
    rdchk("stat_no_first_edge", BASE + 32'h08, 32'h0);
    rdchk("port_in_after_rst", BASE + 32'h04, 32'h07);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, d;
      logic we, re, rst;
      int sel;
      sel = $urandom_range(0, 19);
      if (sel < 16)       a = BASE + 32'($urandom_range(0, 7) * 4);
      else if (sel < 18)  a = BASE + 32'($urandom_range(0, 31));
      else                a = BASE + 32'h20 + 32'($urandom_range(0, 63));
      case ((a - BASE) / 4)
        3:       d = 32'($urandom_range(0, 5));
        4:       d = 32'($urandom_range(0, 7));
        5:       d = $urandom() & 32'h1FF;
        default: d = $urandom();
      endcase
      we  = ($urandom_range(0, 1) == 1);
      re  = ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 3) == 0) cur_pin = 8'($urandom());
      cyc(rst, a, d, we, re, cur_pin, rd, h);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
